cluster_frame_packer: RTL and testbench

Downstream neighbour of the 1536-strip first-8-cluster finder. Once per bunch crossing (every 8 `clock4x` cycles) it takes the eight {address, count} clusters that stage latches, discards invalid slots, tags each surviving cluster with a BX number, and pushes the result as framed 32-bit words into an internal FIFO. The FIFO drains through a valid/ready stream toward the link serializer. Frames are admitted whole or dropped whole when the FIFO cannot hold them.

---
 rtl/cluster_frame_packer_if.sv | 19 +
 rtl/cluster_frame_packer.sv | 203 ++++++++++++++++++++
 tb/tb_cluster_frame_packer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_frame_packer_if.sv
// Framed word stream from cluster_frame_packer toward the link serializer.
// master drives data/valid, slave returns ready.
interface cluster_frame_packer_if;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/cluster_frame_packer.sv
// Packs the eight per-BX clusters into sof/eof framed words through a FWFT FIFO.
// Optional: define CLUSTER_PACKER_OVF_CNT_EN for the saturating drop counter.
module cluster_frame_packer #(
    parameter int FIFO_DEPTH = 64
) (
    input  logic                        clock4x,
    input  logic                        global_reset,
    input  logic                        clusters_valid,
    input  logic                        bc0,
    input  logic [87:0]                 adr_in,
    input  logic [23:0]                 cnt_in,
    cluster_frame_packer_if.master      link,
    output logic [$clog2(FIFO_DEPTH):0] fifo_words,
    output logic                        overflow,
    output logic [15:0]                 overflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = CW + 1;
    localparam logic [11:0] BX_LAST   = 12'd3563;
    localparam logic [10:0] ADR_LIMIT = 11'd1536;
    localparam logic [10:0] ADR_EMPTY = 11'h7FF;

    function automatic logic [3:0] popcnt8(input logic [7:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, m[i]};
        end
        return c;
    endfunction

    function automatic logic [2:0] lowest8(input logic [7:0] m);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                k = 3'(i);
            end
        end
        return k;
    endfunction

    logic [10:0] adr_q [8];
    logic [2:0]  cnt_q [8];
    logic [7:0]  pend_q;
    logic        empty_q;
    logic        first_q;
    logic [3:0]  n_q;
    logic [11:0] bx_q;
    logic [11:0] bx_next;

    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic [7:0]  slot_ok;
    logic [3:0]  n_new;
    logic [3:0]  pend_cnt;
    logic        multi;
    logic [2:0]  idx;
    logic [7:0]  pend_rest;
    logic        wr_slot;
    logic        wr_en;
    logic        wr_ok;
    logic        rd_en;
    logic        full;
    logic [31:0] wr_data;
    logic [FW-1:0] free_w;
    logic [FW-1:0] need_w;
    logic        drop;
    logic        accept;
    logic [11:0] tag;
    logic [11:0] tag_next;

    always_comb begin
        slot_ok = '0;
        for (int i = 0; i < 8; i++) begin
            slot_ok[i] = adr_in[11*i +: 11] < ADR_LIMIT;
        end
    end

    assign n_new     = popcnt8(slot_ok);
    assign pend_cnt  = popcnt8(pend_q);
    assign multi     = pend_cnt > 4'd1;
    assign idx       = lowest8(pend_q);
    assign pend_rest = pend_q & ~(8'd1 << idx);

    // A strobe landing on a multi-word remainder abandons it unwritten.
    assign wr_slot = (pend_q != 8'd0) && !(clusters_valid && multi);
    assign wr_en   = wr_slot || empty_q;

    always_comb begin
        if (empty_q) begin
            wr_data = {2'b11, 4'd0, bx_q, 3'd0, ADR_EMPTY};
        end else begin
            wr_data = {first_q, pend_rest == 8'd0, n_q, bx_q,
                       cnt_q[idx], adr_q[idx]};
        end
    end

    assign rd_en = link.dout_valid && link.dout_ready;
    assign full  = fifo_words == CW'(FIFO_DEPTH);
    assign wr_ok = wr_en && (!full || rd_en);

    // Space still reserved for the running frame counts against the new one.
    assign free_w = FW'(FIFO_DEPTH) - {1'b0, fifo_words} - FW'(pend_cnt);
    assign need_w = (n_new == 4'd0) ? FW'(1) : FW'(n_new);
    assign drop   = clusters_valid && (free_w < need_w);
    assign accept = clusters_valid && !drop;

    assign tag      = bc0 ? 12'd0 : bx_next;
    assign tag_next = (tag == BX_LAST) ? 12'd0 : tag + 12'd1;

    assign link.dout_valid = fifo_words != '0;
    assign link.dout = link.dout_valid ? mem[rd_ptr[AW-1:0]] : 32'd0;

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            pend_q     <= 8'd0;
            empty_q    <= 1'b0;
            first_q    <= 1'b0;
            n_q        <= 4'd0;
            bx_q       <= 12'd0;
            bx_next    <= 12'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_words <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_en})
                2'b10:   fifo_words <= fifo_words + 1'b1;
                2'b01:   fifo_words <= fifo_words - 1'b1;
                default: fifo_words <= fifo_words;
            endcase

            empty_q <= 1'b0;
            if (wr_slot) begin
                pend_q  <= pend_rest;
                first_q <= 1'b0;
            end

            if (clusters_valid) begin
                bx_next <= tag_next;
                if (drop || multi) begin
                    overflow <= 1'b1;
                end
                if (accept) begin
                    pend_q  <= slot_ok;
                    empty_q <= n_new == 4'd0;
                    first_q <= 1'b1;
                    n_q     <= n_new;
                    bx_q    <= tag;
                end else begin
                    pend_q  <= 8'd0;
                end
            end else if (bc0) begin
                bx_next <= 12'd0;
            end
        end
    end

    // Storage needs no reset: the pointers define what is live.
    always_ff @(posedge clock4x) begin
        if (!global_reset && wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
        if (!global_reset && accept) begin
            for (int i = 0; i < 8; i++) begin
                adr_q[i] <= adr_in[11*i +: 11];
                cnt_q[i] <= cnt_in[3*i +: 3];
            end
        end
    end

`ifdef CLUSTER_PACKER_OVF_CNT_EN
    logic [1:0]  ovf_events;
    logic [16:0] ovf_sum;

    // A truncated old frame and a dropped new one can coincide.
    assign ovf_events = {1'b0, drop} + {1'b0, clusters_valid && multi};
    assign ovf_sum    = {1'b0, overflow_cnt} + {15'd0, ovf_events};

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            overflow_cnt <= 16'd0;
        end else if (ovf_sum[16]) begin
            overflow_cnt <= 16'hFFFF;
        end else begin
            overflow_cnt <= ovf_sum[15:0];
        end
    end
`else
    assign overflow_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cluster_frame_packer.sv
// Directed and randomized bench for cluster_frame_packer against a queue model.
// Honours CLUSTER_PACKER_OVF_CNT_EN for the expected drop counter.
module tb_cluster_frame_packer;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        bc0;
    logic [87:0] adr;
    logic [23:0] cnt;
    logic [6:0]  fifo_words;
    logic        overflow;
    logic [15:0] ovf_cnt;

    cluster_frame_packer_if lnk ();

    always #5 clk = ~clk;

    cluster_frame_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock4x        (clk),
        .global_reset   (rst),
        .clusters_valid (stb),
        .bc0            (bc0),
        .adr_in         (adr),
        .cnt_in         (cnt),
        .link           (lnk),
        .fifo_words     (fifo_words),
        .overflow       (overflow),
        .overflow_cnt   (ovf_cnt)
    );

    logic [31:0] fifo_q [$];
    logic [31:0] wr_q [$];
    logic [11:0] m_bx;
    logic        m_ovf;
    int          m_ovf_cnt;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ovf_cnt();
`ifdef CLUSTER_PACKER_OVF_CNT_EN
        return 32'(m_ovf_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Reference: frames become word lists; one list word reaches the FIFO per edge.
    task automatic model_edge();
        int occ, pend, free, n, need, ev;
        logic [11:0] tag;
        logic [10:0] a [8];
        logic [2:0]  c [8];
        occ = fifo_q.size();
        pend = wr_q.size();
        ev = 0;
        n = 0;
        if (rst) begin
            fifo_q.delete();
            wr_q.delete();
            m_bx = 12'd0;
            m_ovf = 1'b0;
            m_ovf_cnt = 0;
            return;
        end
        if (lnk.dout_ready && occ > 0) void'(fifo_q.pop_front());
        if (stb) begin
            tag = bc0 ? 12'd0 : m_bx;
            m_bx = (tag == 12'd3563) ? 12'd0 : tag + 12'd1;
            free = DEPTH - occ - pend;
            if (pend > 1) begin
                wr_q.delete();
                ev++;
            end else if (pend == 1) begin
                fifo_q.push_back(wr_q.pop_front());
            end
            for (int i = 0; i < 8; i++) begin
                if (adr[11*i +: 11] < 11'd1536) begin
                    a[n] = adr[11*i +: 11];
                    c[n] = cnt[3*i +: 3];
                    n++;
                end
            end
            need = (n == 0) ? 1 : n;
            if (free < need) ev++;
            else if (n == 0) wr_q.push_back({2'b11, 4'd0, tag, 3'd0, 11'h7FF});
            else begin
                for (int k = 0; k < n; k++)
                    wr_q.push_back({k == 0, k == n - 1, 4'(n), tag, c[k], a[k]});
            end
            if (ev > 0) m_ovf = 1'b1;
            m_ovf_cnt = (m_ovf_cnt + ev > 65535) ? 65535 : m_ovf_cnt + ev;
        end else begin
            if (bc0) m_bx = 12'd0;
            if (pend > 0) fifo_q.push_back(wr_q.pop_front());
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("fifo_words", 32'(fifo_words), 32'(fifo_q.size()));
        chk("dout_valid", 32'(lnk.dout_valid), 32'(fifo_q.size() > 0));
        chk("dout", lnk.dout, (fifo_q.size() > 0) ? fifo_q[0] : 32'd0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("overflow_cnt", 32'(ovf_cnt), exp_ovf_cnt());
        stb = 1'b0;
        bc0 = 1'b0;
    endtask

    task automatic rand_clusters(input int pct);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 99) < pct)
                adr[11*i +: 11] = 11'($urandom_range(0, 1535));
            else
                adr[11*i +: 11] = 11'($urandom_range(1536, 2047));
            cnt[3*i +: 3] = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        lnk.dout_ready = 1'b1;
        while ((fifo_q.size() > 0 || wr_q.size() > 0) && guard < 300) begin
            tick();
            guard++;
        end
        chk("drain_fifo_words", 32'(fifo_words), 32'd0);
    endtask

    initial begin
        int gap;
        rst = 1'b1;
        stb = 1'b0;
        bc0 = 1'b0;
        adr = '1;
        cnt = '0;
        lnk.dout_ready = 1'b1;
        m_bx = 12'd0;
        m_ovf = 1'b0;
        m_ovf_cnt = 0;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_dout", lnk.dout, 32'd0);
        chk("rst_valid", 32'(lnk.dout_valid), 32'd0);
        chk("rst_words", 32'(fifo_words), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);

        // Two valid slots with bc0.
        adr = {8{11'h7FE}};
        cnt = '0;
        adr[11*2 +: 11] = 11'd100;
        cnt[3*2 +: 3] = 3'd3;
        adr[11*5 +: 11] = 11'd1200;
        cnt[3*5 +: 3] = 3'd0;
        bc0 = 1'b1;
        stb = 1'b1;
        tick();
        tick();
        chk("t1_word0", lnk.dout, 32'h8800_1864);
        tick();
        chk("t1_word1", lnk.dout, 32'h4800_04B0);
        repeat (5) tick();

        // Empty BX, then the following tag.
        adr = '1;
        bc0 = 1'b1;
        stb = 1'b1;
        tick();
        tick();
        chk("t2_empty", lnk.dout, 32'hC000_07FF);
        repeat (6) tick();
        rand_clusters(100);
        stb = 1'b1;
        tick();
        tick();
        chk("t2_next_bx", 32'(lnk.dout[25:14]), 32'd1);
        repeat (6) tick();

        // Back-to-back full frames.
        repeat (16) begin
            rand_clusters(100);
            stb = 1'b1;
            tick();
            repeat (7) tick();
        end
        drain();
        chk("full_no_ovf", 32'(overflow), 32'd0);

        // Stalled consumer: ninth full frame must be dropped whole.
        lnk.dout_ready = 1'b0;
        repeat (9) begin
            rand_clusters(100);
            stb = 1'b1;
            tick();
            repeat (7) tick();
        end
        chk("stall_words", 32'(fifo_words), 32'd64);
        chk("stall_ovf", 32'(overflow), 32'd1);
`ifdef CLUSTER_PACKER_OVF_CNT_EN
        chk("stall_ovf_cnt", 32'(ovf_cnt), 32'd1);
`else
        chk("stall_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
        drain();

        // Reset mid-frame.
        rand_clusters(100);
        stb = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 32'(lnk.dout_valid), 32'd0);
        chk("mrst_words", 32'(fifo_words), 32'd0);
        tick();
        rand_clusters(100);
        stb = 1'b1;
        tick();
        tick();
        chk("mrst_sof", 32'(lnk.dout[31]), 32'd1);
        chk("mrst_bx", 32'(lnk.dout[25:14]), 32'd0);
        repeat (6) tick();

        // BX counter wrap.
        rand_clusters(60);
        bc0 = 1'b1;
        stb = 1'b1;
        tick();
        repeat (7) tick();
        for (int s = 1; s <= 3564; s++) begin
            rand_clusters(60);
            stb = 1'b1;
            tick();
            tick();
            if (s == 3563) chk("wrap_last", 32'(lnk.dout[25:14]), 32'd3563);
            if (s == 3564) chk("wrap_zero", 32'(lnk.dout[25:14]), 32'd0);
            repeat (6) tick();
        end
        drain();

        // Early strobe truncates a running frame.
        rand_clusters(100);
        stb = 1'b1;
        tick();
        repeat (2) tick();
        rand_clusters(100);
        stb = 1'b1;
        tick();
        repeat (7) tick();
        chk("trunc_ovf", 32'(overflow), 32'd1);
        drain();

        // Random traffic with backpressure and stray bc0.
        repeat (400) begin
            rand_clusters($urandom_range(0, 100));
            bc0 = ($urandom_range(0, 15) == 0);
            stb = 1'b1;
            lnk.dout_ready = ($urandom_range(0, 3) != 0);
            tick();
            gap = $urandom_range(7, 11);
            repeat (gap) begin
                lnk.dout_ready = ($urandom_range(0, 3) != 0);
                bc0 = ($urandom_range(0, 40) == 0);
                tick();
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
